fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the decoder.
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel.
- Accepts in-order responses into a small buffer and presents {pc, instr} to decode with a valid/ready handshake.
- Handles redirects (branch, jump, fence.i refetch) by flushing the buffer and discarding responses still in flight.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 55 +++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int unsigned FETCH_W = 32;
   localparam logic [FETCH_W-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [FETCH_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [FETCH_W-1:0] pc;
      logic [FETCH_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [FETCH_W-1:0] align_pc(input logic [FETCH_W-1:0] pc);
      return pc & ~FETCH_W'(3);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of {pc, instr}; flush overrides push and pop.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign do_push = push && !flush && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop && !flush && (count_q != '0);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited memory requests and
// buffers in-order responses for the decoder, discarding stale data after redirects.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [FETCH_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned        DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   output logic [FETCH_W-1:0] imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [FETCH_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [FETCH_W-1:0] redirect_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [FETCH_W-1:0] if_pc,
   output logic [FETCH_W-1:0] if_instr
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [FETCH_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redirect_target;
   logic [CNT_W-1:0]   outst_q, outst_d, drop_q, drop_d, count;
   logic [CNT_W:0]     inflight;
   logic               req_fire, rsp_ok, push, pop;
   fetch_entry_t       head, push_data;

   assign redirect_target = align_pc(redirect_pc);

   // Credit: buffered entries plus outstanding requests never exceed DEPTH.
   assign inflight       = {1'b0, count} + {1'b0, outst_q};
   assign imem_req_valid = !rst && !redirect_valid && (inflight < (CNT_W + 1)'(DEPTH));
   assign imem_req_addr  = pc_q;

   assign req_fire  = imem_req_valid && imem_req_ready;
   assign rsp_ok    = imem_rsp_valid && (outst_q != '0);
   assign push      = rsp_ok && (drop_q == '0) && !redirect_valid;
   assign pop       = if_valid && if_ready;
   assign push_data = '{pc: rsp_pc_q, instr: imem_rsp_data};

   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      outst_d  = outst_q;
      drop_d   = drop_q;
      if (req_fire) begin
         pc_d    = pc_q + FETCH_W'(4);
         outst_d = outst_d + CNT_W'(1);
      end
      if (rsp_ok) begin
         outst_d = outst_d - CNT_W'(1);
         if (drop_q != '0) begin
            drop_d = drop_q - CNT_W'(1);
         end else begin
            rsp_pc_d = rsp_pc_q + FETCH_W'(4);
         end
      end
      // Everything still in flight after this cycle's response belongs to the old stream.
      if (redirect_valid) begin
         pc_d     = redirect_target;
         rsp_pc_d = redirect_target;
         drop_d   = outst_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
      end
   end

   fetch_buffer #(
      .DEPTH(DEPTH)
   ) u_buffer (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .flush    (redirect_valid),
      .count    (count),
      .head     (head)
   );

   assign if_valid = !rst && (count != '0);
   assign if_pc    = if_valid ? head.pc : (rst ? RESET_PC : rsp_pc_q);
   assign if_instr = if_valid ? head.instr : NOP_INSTR;

`ifndef SYNTHESIS
   rsp_needs_request : assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (outst_q != '0))
      else $error("fetch_unit: response with no request outstanding");
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a stream-level
// reference of which PCs must reach decode, with directed and random scenarios.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b1;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC(RST_PC),
      .DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_valid(imem_req_valid),
      .imem_req_addr (imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_pc         (if_pc),
      .if_instr      (if_instr)
   );

   typedef struct { logic [31:0] addr; int due; } mem_t;
   typedef struct { logic [31:0] pc; int cyc; } log_t;

   mem_t        mem_q[$];
   log_t        req_log[$];
   log_t        pop_log[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          mem_lat = 1;
   int          bout = 0;
   bit          rand_lat = 1'b0;
   logic [31:0] exp_fetch = RST_PC;
   logic [31:0] exp_dec = RST_PC;

   // Memory contents: a distinct, non-NOP word for every aligned address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0B};
   endfunction

   // Reference: decode sees consecutive PCs from the last restart point, each with
   // the memory word at that PC; fetch addresses follow the same sequence.
   task automatic observe();
      int lat;
      int due;
      if (rst) begin
         total++;
         if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_quiet: req_valid=%b if_valid=%b required 0 0",
                     imem_req_valid, if_valid);
         end
         mem_q.delete();
         exp_fetch = RST_PC;
         exp_dec   = RST_PC;
         bout      = 0;
      end else begin
         total++;
         if (!if_valid && if_instr !== NOP_INSTR) begin
            bad++;
            $display("FAIL idle_nop: if_instr=%h required %h", if_instr, NOP_INSTR);
         end
         if (redirect_valid) begin
            total++;
            if (imem_req_valid !== 1'b0) begin
               bad++;
               $display("FAIL redirect_no_req: req_valid=%b required 0", imem_req_valid);
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            total++;
            if (imem_req_addr !== exp_fetch) begin
               bad++;
               $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_fetch);
            end
            lat = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due});
            req_log.push_back('{pc: imem_req_addr, cyc: cyc});
            exp_fetch = exp_fetch + 32'd4;
            bout++;
         end
         if (imem_rsp_valid) bout--;
         if (if_valid && if_ready && !redirect_valid) begin
            total++;
            if (if_pc !== exp_dec || if_instr !== word_at(exp_dec)) begin
               bad++;
               $display("FAIL decode_stream: got pc=%h instr=%h required pc=%h instr=%h",
                        if_pc, if_instr, exp_dec, word_at(exp_dec));
            end
            pop_log.push_back('{pc: if_pc, cyc: cyc});
            exp_dec = exp_dec + 32'd4;
         end
         if (redirect_valid) begin
            exp_fetch = {redirect_pc[31:2], 2'b00};
            exp_dec   = {redirect_pc[31:2], 2'b00};
         end
         total++;
         if (bout > int'(DEPTH)) begin
            bad++;
            $display("FAIL credit: outstanding=%0d limit %0d", bout, DEPTH);
         end
      end
   endtask

   task automatic drive_mem();
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_at(mem_q[0].addr);
         void'(mem_q.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      observe();
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
      cyc++;
      drive_mem();
   endtask

   task automatic step();
      to_neg();
      to_next();
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      req_log.delete();
      pop_log.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      to_neg();
      total++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_instr !== NOP_INSTR ||
          if_pc !== RST_PC) begin
         bad++;
         $display("FAIL reset_outputs: req_valid=%b if_valid=%b instr=%h pc=%h",
                  imem_req_valid, if_valid, if_instr, if_pc);
      end
      to_next();
      step();
      rst = 1'b0;
      to_neg();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         bad++;
         $display("FAIL reset_first_req: valid=%b addr=%h required 1 %h",
                  imem_req_valid, imem_req_addr, RST_PC);
      end
      to_next();
   endtask

   task automatic test_stream();
      if_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 1;
      do_reset();
      repeat (10) step();
      total++;
      if (req_log.size() < 3 || req_log[0].pc !== 32'h0 || req_log[1].pc !== 32'h4 ||
          req_log[2].pc !== 32'h8 || req_log[1].cyc != req_log[0].cyc + 1) begin
         bad++;
         $display("FAIL stream_reqs: got %0d requests, required 0,4,8 back to back start",
                  req_log.size());
      end
      total++;
      if (pop_log.size() < 2 || pop_log[0].pc !== 32'h0 ||
          pop_log[0].cyc != req_log[0].cyc + 2 || pop_log[1].cyc != pop_log[0].cyc + 1) begin
         bad++;
         $display("FAIL stream_latency: pops=%0d, required first pop 2 cycles after request",
                  pop_log.size());
      end
   endtask

   task automatic test_backpressure();
      int n;
      if_ready = 1'b0; imem_req_ready = 1'b1; mem_lat = 1;
      do_reset();
      repeat (8) step();
      total++;
      if (req_log.size() != 2) begin
         bad++;
         $display("FAIL bp_req_count: got %0d required 2", req_log.size());
      end
      for (int i = 0; i < 3; i++) begin
         to_neg();
         total++;
         if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0 ||
             if_instr !== word_at(32'h0)) begin
            bad++;
            $display("FAIL bp_hold: req_valid=%b if_valid=%b pc=%h instr=%h",
                     imem_req_valid, if_valid, if_pc, if_instr);
         end
         to_next();
      end
      if_ready = 1'b1;
      req_log.delete();
      n = 0;
      while (req_log.size() < 1 && n < 10) begin step(); n++; end
      total++;
      if (req_log.size() < 1 || req_log[0].pc !== 32'h8) begin
         bad++;
         $display("FAIL bp_resume: requests=%0d, required resume at 00000008", req_log.size());
      end
      repeat (6) step();
   endtask

   task automatic test_redirect_inflight();
      int n;
      if_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 3;
      do_reset();
      n = 0;
      while (req_log.size() < 2 && n < 20) begin step(); n++; end
      total++;
      if (req_log.size() < 2) begin
         bad++;
         $display("FAIL rdi_setup: requests=%0d required 2", req_log.size());
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0107;
      to_neg();
      to_next();
      redirect_valid = 1'b0;
      req_log.delete();
      pop_log.delete();
      n = 0;
      while (pop_log.size() < 2 && n < 40) begin step(); n++; end
      total++;
      if (req_log.size() < 1 || req_log[0].pc !== 32'h0000_0104) begin
         bad++;
         $display("FAIL rdi_req: requests=%0d, required first at 00000104", req_log.size());
      end
      total++;
      if (pop_log.size() < 2 || pop_log[0].pc !== 32'h0000_0104) begin
         bad++;
         $display("FAIL rdi_pop: pops=%0d, required first pc 00000104", pop_log.size());
      end
   endtask

   task automatic test_redirect_same_cycle();
      int n;
      if_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 1;
      do_reset();
      n = 0;
      while (!(imem_rsp_valid && if_valid) && n < 20) begin step(); n++; end
      total++;
      if (!(imem_rsp_valid && if_valid)) begin
         bad++;
         $display("FAIL rds_setup: rsp_valid=%b if_valid=%b required 1 1",
                  imem_rsp_valid, if_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      to_neg();
      to_next();
      redirect_valid = 1'b0;
      req_log.delete();
      pop_log.delete();
      to_neg();
      total++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         bad++;
         $display("FAIL rds_after: if_valid=%b req_valid=%b addr=%h required 0 1 00000200",
                  if_valid, imem_req_valid, imem_req_addr);
      end
      to_next();
      n = 0;
      while (pop_log.size() < 2 && n < 20) begin step(); n++; end
      total++;
      if (pop_log.size() < 2 || pop_log[0].pc !== 32'h200 || pop_log[1].pc !== 32'h204) begin
         bad++;
         $display("FAIL rds_stream: pops=%0d, required 00000200 then 00000204",
                  pop_log.size());
      end
   endtask

   task automatic test_req_stall();
      int n;
      if_ready = 1'b1; imem_req_ready = 1'b0; mem_lat = 1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         to_neg();
         total++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            bad++;
            $display("FAIL stall_hold: valid=%b addr=%h required 1 %h",
                     imem_req_valid, imem_req_addr, RST_PC);
         end
         to_next();
      end
      imem_req_ready = 1'b1;
      n = 0;
      while (pop_log.size() < 4 && n < 30) begin step(); n++; end
      total++;
      if (pop_log.size() < 4 || pop_log[0].pc !== 32'h0 || pop_log[3].pc !== 32'hC) begin
         bad++;
         $display("FAIL stall_order: pops=%0d, required 0,4,8,c", pop_log.size());
      end
   endtask

   task automatic test_wrap_and_reset();
      int n;
      if_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      step();
      redirect_valid = 1'b0;
      req_log.delete();
      pop_log.delete();
      n = 0;
      while (pop_log.size() < 2 && n < 30) begin step(); n++; end
      total++;
      if (req_log.size() < 2 || req_log[0].pc !== 32'hFFFF_FFFC || req_log[1].pc !== 32'h0)
      begin
         bad++;
         $display("FAIL wrap_req: requests=%0d, required fffffffc then 00000000",
                  req_log.size());
      end
      total++;
      if (pop_log.size() < 2 || pop_log[0].pc !== 32'hFFFF_FFFC || pop_log[1].pc !== 32'h0)
      begin
         bad++;
         $display("FAIL wrap_pop: pops=%0d, required fffffffc then 00000000", pop_log.size());
      end
      mem_lat = 3;
      repeat (3) step();
      rst = 1'b1;
      to_neg();
      total++;
      if (if_valid !== 1'b0 || if_pc !== RST_PC) begin
         bad++;
         $display("FAIL midrst_outputs: if_valid=%b if_pc=%h required 0 %h",
                  if_valid, if_pc, RST_PC);
      end
      to_next();
      rst = 1'b0;
      req_log.delete();
      pop_log.delete();
      to_neg();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         bad++;
         $display("FAIL midrst_req: valid=%b addr=%h required 1 %h",
                  imem_req_valid, imem_req_addr, RST_PC);
      end
      to_next();
      repeat (12) step();
   endtask

   task automatic test_random();
      if_ready = 1'b1; imem_req_ready = 1'b1; rand_lat = 1'b1;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if_ready       = ($urandom_range(0, 9) < 7);
         imem_req_ready = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 29) == 0);
         redirect_pc    = $urandom;
         step();
      end
      redirect_valid = 1'b0;
      if_ready       = 1'b1;
      imem_req_ready = 1'b1;
      repeat (10) step();
      total++;
      if (pop_log.size() < 60) begin
         bad++;
         $display("FAIL random_progress: pops=%0d required at least 60", pop_log.size());
      end
      rand_lat = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_same_cycle();
      test_req_stall();
      test_wrap_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
